// File: rtl/pend_dispatch_pkg.sv
// Purpose : shared types and elaboration-time parameter checks for pend_dispatch.
// Contents: state_t FSM encoding, helper functions validating N / K.
package pend_dispatch_pkg;

   // Dispatcher FSM: IDLE waits for the encoder, OFFER holds a grant until accepted.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // True when n is a power of two and at least 2.
   function automatic bit is_pow2(input int unsigned n);
      return (n >= 32'd2) && ((n & (n - 32'd1)) == 32'd0);
   endfunction

   // True when k is exactly log2(n).
   function automatic bit idx_width_ok(input int unsigned n, input int unsigned k);
      return (k < 32'd32) && ((32'd1 << k) == n);
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Purpose : recursive index -> one-hot decoder with enable, halving at each level
//           the same way the upstream priority encoder splits its input.
// Ports   : idx [K] index to decode
//           en       enable; y is all-zero when low
//           y   [N]  one-hot result
module onehot_dec #(
   parameter int unsigned N = 8,
   parameter int unsigned K = 3
) (
   input  logic [K-1:0] idx,
   input  logic         en,
   output logic [N-1:0] y
);

   if (N == 2) begin : g_base
      // Two outputs: bit 1 for idx=1, bit 0 for idx=0.
      assign y = en ? {idx[0], ~idx[0]} : 2'b00;
   end else begin : g_split
      localparam int unsigned H = N / 2;

      logic [H-1:0] y_hi;
      logic [H-1:0] y_lo;

      // Index MSB steers the enable into exactly one half.
      onehot_dec #(.N(H), .K(K - 1)) u_hi (
         .idx (idx[K-2:0]),
         .en  (en & idx[K-1]),
         .y   (y_hi)
      );

      onehot_dec #(.N(H), .K(K - 1)) u_lo (
         .idx (idx[K-2:0]),
         .en  (en & ~idx[K-1]),
         .y   (y_lo)
      );

      assign y = {y_hi, y_lo};
   end

endmodule

// File: rtl/pend_dispatch.sv
// Purpose : pending-request register plus grant dispatcher on the output side of
//           an external priority encoder. Requests accumulate in pend; the
//           encoder's choice becomes a valid/ready grant; an accepted grant
//           clears its pending bit (a same-cycle request keeps it set).
// Ports   : clk, rst           clock, synchronous active-high reset
//           req [N]            per-source set pulses
//           pend [N]           registered pending vector to the encoder
//           sel_idx [K]        encoder index of highest pending bit
//           sel_none           encoder reports nothing pending
//           out_valid/out_idx  grant offer (held until accepted)
//           out_ready          consumer accepts the grant
//           coalesce_cnt [CW]  saturating count of cycles a request hit a pending bit
module pend_dispatch
   import pend_dispatch_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned K  = 3,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  pend,
   input  logic [K-1:0]  sel_idx,
   input  logic          sel_none,
   output logic          out_valid,
   output logic [K-1:0]  out_idx,
   input  logic          out_ready,
   output logic [CW-1:0] coalesce_cnt
);

   if (!is_pow2(N) || !idx_width_ok(N, K)) begin : g_param_err
      $error("pend_dispatch: N must be a power of two >= 2 and K must equal log2(N)");
   end

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   state_t        state_q, state_d;
   logic [N-1:0]  pend_q, pend_d;
   logic          out_valid_q, out_valid_d;
   logic [K-1:0]  out_idx_q, out_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          hs_c;
   logic [N-1:0]  clr_c;
   logic          hit_c;

   assign hs_c = out_valid_q & out_ready;

   // Clear mask for the granted source; zero unless a handshake happens.
   onehot_dec #(.N(N), .K(K)) u_dec (
      .idx (out_idx_q),
      .en  (hs_c),
      .y   (clr_c)
   );

   // Pending vector and coalesce counter next-state; set wins over clear.
   always_comb begin
      pend_d = (pend_q & ~clr_c) | req;
      hit_c  = |(req & pend_q & ~clr_c);
      cnt_d  = cnt_q;
      if (hit_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Offer FSM: latch the encoder result in IDLE, hold it in OFFER until accepted.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      case (state_q)
         IDLE: begin
            if (!sel_none) begin
               out_idx_d   = sel_idx;
               out_valid_d = 1'b1;
               state_d     = OFFER;
            end
         end
         OFFER: begin
            if (hs_c) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         cnt_q       <= cnt_d;
      end
   end

   assign pend         = pend_q;
   assign out_valid    = out_valid_q;
   assign out_idx      = out_idx_q;
   assign coalesce_cnt = cnt_q;

endmodule
